// File: rtl/rr_ready_queue.sv
// Round-robin ready-queue dispatcher: a FIFO of ready PIDs feeding one running slot
// that handshakes with an external quantum timer.
module rr_ready_queue #(
  parameter int DEPTH = 8,
  parameter int PID_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     add_valid,
  input  logic [PID_W-1:0]         add_pid,
  output logic                     add_ready,
  input  logic                     quantum_expired,
  input  logic                     kill,
  output logic                     timer_start,
  output logic [PID_W-1:0]         cur_pid,
  output logic                     running,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt;
  logic [PID_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [PID_W-1:0]   cur_pid_r;
  logic               timer_start_r;
  logic               running_r;
  logic               pop;
  logic               requeue;
  logic               add_fire;
  logic               push;
  logic [PID_W-1:0]   push_data;

  // Next-state decode; pop and re-enqueue are FSM side effects.
  always_comb begin
    state_nxt = state_r;
    pop       = 1'b0;
    requeue   = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != '0) begin
          pop       = 1'b1;
          state_nxt = DISPATCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      DISPATCH: state_nxt = RUN;
      RUN: begin
        if (kill) begin
          state_nxt = IDLE;
        end else if (quantum_expired) begin
          requeue   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outside IDLE one slot stays reserved so a preempted PID always fits back in.
  always_comb begin
    add_ready = 1'b0;
    if (requeue) begin
      add_ready = 1'b0;
    end else if (state_r == IDLE) begin
      add_ready = (count_r < DEPTH_C);
    end else begin
      add_ready = (count_r < DEPTH_M1_C);
    end
  end

  assign add_fire  = add_valid && add_ready && (add_pid != '0);
  assign push      = add_fire || requeue;
  assign push_data = requeue ? cur_pid_r : add_pid;

  // Queue storage needs no reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy, FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      count_r       <= '0;
      cur_pid_r     <= '0;
      timer_start_r <= 1'b0;
      running_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      timer_start_r <= (state_nxt == DISPATCH);
      running_r     <= (state_nxt != IDLE);
      count_r       <= count_r + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
        cur_pid_r <= mem[rd_ptr_r];
      end else if (state_r == RUN && state_nxt == IDLE) begin
        cur_pid_r <= '0;
      end
    end
  end

  assign timer_start = timer_start_r;
  assign running     = running_r;
  assign cur_pid     = cur_pid_r;
  assign count       = count_r;

endmodule

// File: tb/tb_rr_ready_queue.sv
// Self-checking bench for rr_ready_queue: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_rr_ready_queue;

  localparam int DEPTH = 8;
  localparam int PID_W = 5;

  logic             clk;
  logic             reset;
  logic             add_valid;
  logic [PID_W-1:0] add_pid;
  logic             add_ready;
  logic             quantum_expired;
  logic             kill;
  logic             timer_start;
  logic [PID_W-1:0] cur_pid;
  logic             running;
  logic [3:0]       count;

  rr_ready_queue #(.DEPTH(DEPTH), .PID_W(PID_W)) dut (
    .clk(clk), .reset(reset), .add_valid(add_valid), .add_pid(add_pid),
    .add_ready(add_ready), .quantum_expired(quantum_expired), .kill(kill),
    .timer_start(timer_start), .cur_pid(cur_pid), .running(running), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_seen;

  // Reference model: 0 = idle, 1 = dispatching, 2 = running
  int mq[$];
  int mphase;
  int mcur;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_ready(input logic qe, input logic kl);
    if (mphase == 2 && qe && !kl) return 0;
    if (mphase == 0) return (mq.size() < DEPTH) ? 1 : 0;
    return (mq.size() < DEPTH - 1) ? 1 : 0;
  endfunction

  task automatic model_edge(input logic av, input int pid, input logic qe, input logic kl, input int rdy);
    case (mphase)
      0: if (mq.size() > 0) begin mcur = mq.pop_front(); mphase = 1; end
      1: mphase = 2;
      default: begin
        if (kl) begin mcur = 0; mphase = 0; end
        else if (qe) begin mq.push_back(mcur); mcur = 0; mphase = 0; end
      end
    endcase
    if (av && rdy == 1 && pid != 0) mq.push_back(pid);
  endtask

  task automatic model_reset();
    mq.delete();
    mphase = 0;
    mcur = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_cur_pid"}, int'(cur_pid), mcur);
    chk({tag, "_running"}, int'(running), (mphase != 0) ? 1 : 0);
    chk({tag, "_timer_start"}, int'(timer_start), (mphase == 1) ? 1 : 0);
    chk({tag, "_count"}, int'(count), mq.size());
  endtask

  task automatic step(input logic av, input int pid, input logic qe, input logic kl);
    int rdy;
    @(negedge clk);
    add_valid = av;
    add_pid = PID_W'(pid);
    quantum_expired = qe;
    kill = kl;
    #1;
    rdy = model_ready(qe, kl);
    ready_seen = int'(add_ready);
    chk("add_ready", ready_seen, rdy);
    @(posedge clk);
    model_edge(av, pid, qe, kl, rdy);
    #1;
    check_outputs("step");
  endtask

  task automatic wait_run(input string tag);
    bit reached = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (running && !timer_start) begin
        reached = 1'b1;
        break;
      end
      step(1'b0, 0, 1'b0, 1'b0);
    end
    if (!reached) chk({tag, "_wait_run_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    add_valid = 1'b0; add_pid = '0; quantum_expired = 1'b0; kill = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_async_count", int'(count), 0);
    chk("rst_async_cur_pid", int'(cur_pid), 0);
    chk("rst_async_running", int'(running), 0);
    chk("rst_async_timer_start", int'(timer_start), 0);
    chk("rst_async_add_ready", int'(add_ready), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs("rst_release");
    chk("rst_release_add_ready", int'(add_ready), 1);
  endtask

  typedef struct {
    logic av; int pid; logic qe; logic kl;
    int rdy; int cur; int run; int ts; int cnt;
  } vec_t;

  vec_t vecs[16];
  int order[$];
  int exp_rr[6] = '{3, 7, 9, 3, 7, 9};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    //              av    pid qe    kl    rdy cur run ts cnt
    vecs[0]  = '{1'b1, 5, 1'b0, 1'b0, 1, 0, 0, 0, 1};
    vecs[1]  = '{1'b0, 0, 1'b0, 1'b0, 1, 5, 1, 1, 0};
    vecs[2]  = '{1'b0, 0, 1'b0, 1'b0, 1, 5, 1, 0, 0};
    vecs[3]  = '{1'b0, 0, 1'b0, 1'b0, 1, 5, 1, 0, 0};
    vecs[4]  = '{1'b0, 0, 1'b1, 1'b0, 0, 0, 0, 0, 1};
    vecs[5]  = '{1'b0, 0, 1'b0, 1'b0, 1, 5, 1, 1, 0};
    vecs[6]  = '{1'b0, 0, 1'b1, 1'b0, 1, 5, 1, 0, 0};
    vecs[7]  = '{1'b1, 0, 1'b0, 1'b0, 1, 5, 1, 0, 0};
    vecs[8]  = '{1'b1, 3, 1'b1, 1'b0, 0, 0, 0, 0, 1};
    vecs[9]  = '{1'b1, 7, 1'b0, 1'b0, 1, 5, 1, 1, 1};
    vecs[10] = '{1'b0, 0, 1'b0, 1'b0, 1, 5, 1, 0, 1};
    vecs[11] = '{1'b0, 0, 1'b1, 1'b1, 1, 0, 0, 0, 1};
    vecs[12] = '{1'b0, 0, 1'b0, 1'b0, 1, 7, 1, 1, 0};
    vecs[13] = '{1'b0, 0, 1'b0, 1'b0, 1, 7, 1, 0, 0};
    vecs[14] = '{1'b0, 0, 1'b0, 1'b1, 1, 0, 0, 0, 0};
    vecs[15] = '{1'b0, 0, 1'b0, 1'b0, 1, 0, 0, 0, 0};

    reset = 1'b1;
    add_valid = 1'b0; add_pid = '0; quantum_expired = 1'b0; kill = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    do_reset();

    // Directed table: single process, ignored events, zero PID, kill priority
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].av, vecs[i].pid, vecs[i].qe, vecs[i].kl);
      chk($sformatf("vec%0d_add_ready", i), ready_seen, vecs[i].rdy);
      chk($sformatf("vec%0d_cur_pid", i), int'(cur_pid), vecs[i].cur);
      chk($sformatf("vec%0d_running", i), int'(running), vecs[i].run);
      chk($sformatf("vec%0d_timer_start", i), int'(timer_start), vecs[i].ts);
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
    end

    // Round robin 3,7,9 with a quantum expiry every time RUN is reached
    do_reset();
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 1'b0);
    step(1'b1, 9, 1'b0, 1'b0);
    order.delete();
    for (int k = 0; k < 6; k++) begin
      wait_run("rr");
      order.push_back(int'(cur_pid));
      chk("rr_count_in_run", int'(count), 2);
      step(1'b0, 0, 1'b1, 1'b0);
    end
    for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), order[k], exp_rr[k]);

    // Backpressure: fill while running, then preempt into a full queue
    do_reset();
    step(1'b1, 1, 1'b0, 1'b0);
    wait_run("bp");
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 10 + i, 1'b0, 1'b0);
      chk("bp_add_accept", ready_seen, 1);
    end
    step(1'b1, 17, 1'b0, 1'b0);
    chk("bp_8th_add_ready", ready_seen, 0);
    chk("bp_count_7", int'(count), 7);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("bp_count_full", int'(count), 8);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("bp_full_idle_add_ready", ready_seen, 0);
    order.delete();
    for (int k = 0; k < 8; k++) begin
      wait_run("bp");
      order.push_back(int'(cur_pid));
      step(1'b0, 0, 1'b0, 1'b1);
    end
    for (int k = 0; k < 7; k++) chk($sformatf("bp_order%0d", k), order[k], 10 + k);
    chk("bp_order7", order[7], 1);

    // Reset mid-RUN with four entries queued
    step(1'b1, 2, 1'b0, 1'b0);
    wait_run("rst");
    for (int i = 0; i < 4; i++) step(1'b1, 4 + 2 * i, 1'b0, 1'b0);
    chk("rst_pre_count", int'(count), 4);
    do_reset();
    step(1'b0, 0, 1'b0, 1'b0);
    chk("rst_post_idle_count", int'(count), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic av, qe, kl;
      int pid;
      av  = ($urandom_range(0, 1) == 1);
      pid = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
      qe  = ($urandom_range(0, 5) == 0);
      kl  = ($urandom_range(0, 9) == 0);
      step(av, pid, qe, kl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
